// File: rtl/bram_dp_loader.sv
// Dual-port block RAM with HPS download loader, power-on clear engine and optional ROM mode.
// Latency: 1-cycle registered reads on both ports; writes visible to reads issued the next cycle.
// Backpressure: none; port A writes are dropped outside IDLE (or always when ROM=1); reads never stall.
//
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   dl_active/dl_wr/dl_addr/dl_din     download stream in; dl_done/dl_count/dl_overflow status out
//   busy                               high while clearing or loading
//   a_cs/a_we/a_addr/a_din/a_dout      CPU port, read-first, write only in IDLE
//   b_cs/b_addr/b_dout                 read-only video/DMA port
module bram_dp_loader #(
    parameter int DW    = 8,
    parameter int AW    = 12,
    parameter int ROM   = 0,
    parameter int CLEAR = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [DW-1:0] dl_din,
    output logic          dl_done,
    output logic [AW:0]   dl_count,
    output logic          dl_overflow,
    output logic          busy,
    input  logic          a_cs,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    input  logic          b_cs,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_dout
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [AW:0]   dl_count_q, dl_count_d;
    logic          dl_done_q, dl_done_d;
    logic          dl_ovf_q, dl_ovf_d;
    logic [DW-1:0] a_dout_q, a_dout_d;
    logic [DW-1:0] b_dout_q, b_dout_d;

    // Single write port: clear, loader and port A are mutually exclusive by state.
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic          dl_in_range;
    assign dl_in_range = (dl_addr >> AW) == '0;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        dl_count_d = dl_count_q;
        dl_done_d  = 1'b0;
        dl_ovf_d   = dl_ovf_q;
        mem_we     = 1'b0;
        mem_waddr  = clr_cnt_q;
        mem_wdata  = '0;

        // Read-first: the registered read sees the array before this cycle's write.
        a_dout_d = a_cs ? mem[a_addr] : a_dout_q;
        b_dout_d = b_cs ? mem[b_addr] : b_dout_q;

        case (state_q)
            S_CLEAR: begin
                if (dl_active) begin
                    // Download pre-empts the clear; this cycle's clear write is skipped.
                    state_d    = S_LOAD;
                    dl_count_d = '0;
                    dl_ovf_d   = 1'b0;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_cnt_q;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (dl_active) begin
                    state_d    = S_LOAD;
                    dl_count_d = '0;
                    dl_ovf_d   = 1'b0;
                end
                if (a_cs && a_we && (ROM == 0)) begin
                    mem_we    = 1'b1;
                    mem_waddr = a_addr;
                    mem_wdata = a_din;
                end
            end
            S_LOAD: begin
                if (!dl_active) begin
                    // A strobe coinciding with the falling dl_active is ignored.
                    dl_done_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (dl_wr) begin
                    if (dl_in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = dl_addr[AW-1:0];
                        mem_wdata = dl_din;
                        if (dl_count_q != CNT_MAX) begin
                            dl_count_d = dl_count_q + 1'b1;
                        end
                    end else begin
                        dl_ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= (CLEAR != 0) ? S_CLEAR : S_IDLE;
            clr_cnt_q  <= '0;
            dl_count_q <= '0;
            dl_done_q  <= 1'b0;
            dl_ovf_q   <= 1'b0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            dl_count_q <= dl_count_d;
            dl_done_q  <= dl_done_d;
            dl_ovf_q   <= dl_ovf_d;
            a_dout_q   <= a_dout_d;
            b_dout_q   <= b_dout_d;
        end
    end

    // Array has no reset; writes are suppressed in the reset cycle itself.
    always_ff @(posedge clk) begin
        if (mem_we && reset_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dl_done     = dl_done_q;
    assign dl_count    = dl_count_q;
    assign dl_overflow = dl_ovf_q;
    assign busy        = (state_q != S_IDLE);
    assign a_dout      = a_dout_q;
    assign b_dout      = b_dout_q;

endmodule
